// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Segment patterns here are active-high: bit0 = a ... bit6 = g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pat;
        case (value)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // Largest value representable in 'digits' decimal digits.
    function automatic longint dec_max(input int digits);
        longint v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        return v - 1;
    endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Iterative double-dabble converter: one shift-and-adjust step per cycle,
// 'done' pulses for one cycle once all W input bits have been shifted in.
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W);

    logic [W-1:0]  shreg;
    logic [W-1:0]  acc;
    logic [W-1:0]  adj;
    logic [CW-1:0] cnt;
    logic          busy;

    // The caller guarantees the value fits in DIGITS digits, so the
    // accumulator never needs a digit beyond the top one.
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shreg <= bin;
                acc   <= '0;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                acc   <= W'({adj, shreg[W-1]});
                shreg <= shreg << 1;
                cnt   <= cnt + 1'b1;
                if (cnt == CW'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = acc;

endmodule

// File: rtl/seg7_display_ctrl.sv
// N-digit seven-segment controller with hex/decimal write port, double-buffered
// commit, overflow dashes and blink. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int BLINK_DIV      = 24,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic                  wr_mode,
    input  logic                  blink_en,
    output logic [7*DIGITS-1:0]   segments
);

    localparam int          W       = 4 * DIGITS;
    localparam logic [W-1:0] DEC_MAX = W'(dec_max(DIGITS));

    state_t               state, state_nxt;
    logic                 conv_start;
    logic                 conv_done;
    logic [W-1:0]         conv_bcd;
    logic                 ovf_pend;
    logic [W-1:0]         disp;
    logic                 disp_ovf;
`ifdef SEG7_LZ_BLANK_EN
    logic                 disp_dec;
`endif
    logic [BLINK_DIV-1:0] blink_cnt;

    seg7_bin2bcd #(.DIGITS(DIGITS)) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (wr_data),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        state_nxt  = state;
        wr_ready   = 1'b0;
        conv_start = 1'b0;
        case (state)
            ST_IDLE: begin
                wr_ready = !rst;
                if (wr_valid && !rst && wr_mode == MODE_DEC) begin
                    conv_start = 1'b1;
                    state_nxt  = ST_CONV;
                end
            end
            ST_CONV: if (conv_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            disp      <= '0;
            disp_ovf  <= 1'b0;
            ovf_pend  <= 1'b0;
            blink_cnt <= '0;
`ifdef SEG7_LZ_BLANK_EN
            disp_dec  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            blink_cnt <= blink_cnt + 1'b1;
            if (wr_ready && wr_valid && wr_mode == MODE_HEX) begin
                disp     <= wr_data;
                disp_ovf <= 1'b0;
`ifdef SEG7_LZ_BLANK_EN
                disp_dec <= 1'b0;
`endif
            end
            if (conv_start) ovf_pend <= (wr_data > DEC_MAX);
            // The display register only changes here, so the old value stays up during conversion.
            if (state == ST_CONV && conv_done) begin
                disp     <= conv_bcd;
                disp_ovf <= ovf_pend;
`ifdef SEG7_LZ_BLANK_EN
                disp_dec <= 1'b1;
`endif
            end
        end
    end

    always_comb begin
        logic [6:0] pat;
        logic       lead;
        segments = '0;
        lead     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            pat = disp_ovf ? SEG_DASH : hex_to_seg(disp[4*i +: 4]);
`ifdef SEG7_LZ_BLANK_EN
            if (disp_dec && !disp_ovf && lead && i != 0 && disp[4*i +: 4] == 4'd0)
                pat = SEG_BLANK;
            if (disp[4*i +: 4] != 4'd0) lead = 1'b0;
`else
            lead = 1'b0;
`endif
            if (blink_en && blink_cnt[BLINK_DIV-1]) pat = SEG_BLANK;
            segments[7*i +: 7] = SEG_ACTIVE_LOW ? ~pat : pat;
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl (DIGITS=6, BLINK_DIV=4, active-low);
// expected segments come from a decimal/hex digit model and a lookup table.
module tb_seg7_display_ctrl;

    localparam int DIGITS = 6;
    localparam int W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [W-1:0]  wr_data;
    logic          wr_mode;
    logic          blink_en;
    logic [41:0]   segments;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seg7_display_ctrl #(
        .DIGITS(DIGITS), .BLINK_DIV(4), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_mode(wr_mode), .blink_en(blink_en),
        .segments(segments)
    );

    // Reference model: free-running cycle count and the committed digits.
    logic [3:0] mcnt;
    always @(posedge clk) mcnt <= rst ? 4'd0 : mcnt + 4'd1;

    int m_dig[DIGITS];
    bit m_ovf;
    bit m_dec;

    logic [6:0] lit_tbl[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    localparam logic [41:0] ALL_ZERO  = {6{7'h40}};
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    function automatic logic [41:0] expected();
        logic [41:0] r;
        logic [6:0]  p;
`ifdef SEG7_LZ_BLANK_EN
        int hi = 0;
        for (int i = 0; i < DIGITS; i++) if (m_dig[i] != 0) hi = i;
`endif
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            p = m_ovf ? 7'h40 : lit_tbl[m_dig[i]];
`ifdef SEG7_LZ_BLANK_EN
            if (m_dec && !m_ovf && i > hi) p = 7'h00;
`endif
            if (blink_en && mcnt[3]) p = 7'h00;
            r[7*i +: 7] = ~p;
        end
        return r;
    endfunction

    task automatic set_hex(input logic [W-1:0] d);
        for (int i = 0; i < DIGITS; i++) m_dig[i] = int'((d >> (4 * i)) & 24'hF);
        m_ovf = 1'b0;
        m_dec = 1'b0;
    endtask

    task automatic set_dec(input int v);
        int t = v;
        m_dec = 1'b1;
        m_ovf = (v > 999999);
        if (!m_ovf) begin
            for (int i = 0; i < DIGITS; i++) begin
                m_dig[i] = t % 10;
                t = t / 10;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hex_write(input string tag, input logic [W-1:0] d);
        check({tag, "_ready_before"}, 64'(wr_ready), 64'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_mode  = 1'b0;
        step();
        wr_valid = 1'b0;
        set_hex(d);
        check({tag, "_seg"}, 64'(segments), 64'(expected()));
        check({tag, "_ready_after"}, 64'(wr_ready), 64'd1);
    endtask

    // Decimal write: display must hold through W+1 busy cycles, then commit.
    task automatic dec_write(input string tag, input int v, input int pulse_at);
        logic [41:0] old;
        logic        busy_ok;
        logic        hold_ok;
        check({tag, "_ready_before"}, 64'(wr_ready), 64'd1);
        wr_valid = 1'b1;
        wr_data  = W'(v);
        wr_mode  = 1'b1;
        step();
        wr_valid = 1'b0;
        old      = expected();
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        for (int i = 0; i <= W; i++) begin
            if (wr_ready !== 1'b0) busy_ok = 1'b0;
            if (segments !== old) hold_ok = 1'b0;
            if (i == pulse_at) begin
                wr_valid = 1'b1;
                wr_data  = W'($urandom);
                wr_mode  = 1'($urandom);
            end
            step();
            wr_valid = 1'b0;
        end
        check({tag, "_ready_low_during_conv"}, 64'(busy_ok), 64'd1);
        check({tag, "_display_held"}, 64'(hold_ok), 64'd1);
        set_dec(v);
        check({tag, "_seg"}, 64'(segments), 64'(expected()));
        check({tag, "_ready_after"}, 64'(wr_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int blanks;
        int v;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_mode  = 1'b0;
        blink_en = 1'b0;
        set_hex('0);

        // Reset held two cycles.
        step();
        check("rst_ready_low", 64'(wr_ready), 64'd0);
        check("rst_seg_zero", 64'(segments), 64'(ALL_ZERO));
        step();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(wr_ready), 64'd1);
        check("post_rst_seg", 64'(segments), 64'(ALL_ZERO));

        // Hex write from the test plan.
        hex_write("hex_12AB3F", 24'h12AB3F);
        check("hex_12AB3F_const", 64'(segments),
              64'({7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E}));

        // Largest decimal value, with an ignored write mid-conversion.
        dec_write("dec_999999", 999999, 10);
        check("dec_999999_const", 64'(segments), 64'({6{7'h10}}));

        // Overflow, then a small value.
        dec_write("dec_ovf", 1000000, -1);
        check("dec_ovf_const", 64'(segments), 64'({6{7'h3F}}));
        dec_write("dec_42", 42, -1);
`ifdef SEG7_LZ_BLANK_EN
        check("dec_42_const", 64'(segments), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}));
`else
        check("dec_42_const", 64'(segments), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24}));
`endif
        dec_write("dec_0", 0, -1);
`ifdef SEG7_LZ_BLANK_EN
        check("dec_0_const", 64'(segments), 64'({{5{7'h7F}}, 7'h40}));
`else
        check("dec_0_const", 64'(segments), 64'(ALL_ZERO));
`endif

        // Hex after decimal: no blanking of hex zeros.
        hex_write("hex_000F00", 24'h000F00);

        // Blink: half of every 16-cycle window is blank, in phase with the counter.
        blink_en = 1'b1;
        #1;
        blanks = 0;
        for (int i = 0; i < 32; i++) begin
            if (segments === ALL_BLANK) blanks++;
            if (i % 4 == 0) check("blink_seg", 64'(segments), 64'(expected()));
            step();
        end
        check("blink_duty", 64'(blanks), 64'd16);
        blink_en = 1'b0;
        #1;
        check("blink_off_seg", 64'(segments), 64'(expected()));

        // Reset during a conversion aborts it.
        wr_valid = 1'b1;
        wr_data  = 24'd123456;
        wr_mode  = 1'b1;
        step();
        wr_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #1;
        check("rst_conv_ready_low", 64'(wr_ready), 64'd0);
        step();
        step();
        set_hex('0);
        check("rst_conv_seg_zero", 64'(segments), 64'(ALL_ZERO));
        rst = 1'b0;
        repeat (W + 4) step();
        check("rst_conv_no_commit", 64'(segments), 64'(ALL_ZERO));
        check("rst_conv_ready", 64'(wr_ready), 64'd1);
        hex_write("hex_after_abort", 24'hC0FFEE);

        // Randomized writes checked against the model.
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                hex_write("rand_hex", W'($urandom));
            end else begin
                case ($urandom_range(0, 2))
                    0:       v = int'($urandom_range(0, 999));
                    1:       v = int'($urandom_range(0, 999999));
                    default: v = int'($urandom_range(1000000, 16777215));
                endcase
                dec_write("rand_dec", v, int'($urandom_range(0, W)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
